store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Store-side front end for the data BRAM; sits between the Memory stage and the single-port data RAM.
- The data RAM has a synchronous 1-cycle read and full-word writes only, with no byte enables.
- Word stores (sw) pass straight through in one cycle.
- Byte/half stores (sb, sh) run a read-modify-write (RMW): read the word, merge the lane(s), write it back. The pipeline is stalled for one cycle while this happens.
- Loads pass straight through; load lane selection stays in the downstream read-data formatter.

Parameters:
- ADDR_W, 32, width of the byte address driven to the data RAM.
- CNT_W, 16, width of the saturating RMW event counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- MemWrite  in  1  store request from M stage
- ByteAccessM  in  2  access size: 00 word, 01 byte, 10 half, 11 treated as word
- ALUResultM  in  ADDR_W  byte address of the M-stage access
- WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ram_rdata  in  32  data RAM read data (valid one cycle after the address)
- ram_we  out  1  data RAM write enable
- ram_addr  out  ADDR_W  data RAM address
- ram_wdata  out  32  data RAM write data
- StallM  out  1  freeze PC, F, D, E and M pipeline registers
- misaligned  out  1  one-cycle pulse: half store with ALUResultM[0]=1
- rmw_count  out  CNT_W  number of completed RMW writes, saturating

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- States: IDLE, MERGE.
- Reset (asynchronous, any state):
  - state goes to IDLE; latched address, data and size are cleared; rmw_count is cleared.
  - Outputs while reset is held: ram_we=0, StallM=0, misaligned=0, ram_addr=0, ram_wdata=0.
- IDLE, no store, or word store (size 00 or 11):
  - ram_addr=ALUResultM, ram_we=MemWrite, ram_wdata=WriteData, StallM=0. Zero added latency.
- IDLE, sub-word store (MemWrite=1, size 01 or 10) in cycle N:
  - Drive ram_we=0 and ram_addr={ALUResultM[ADDR_W-1:2],2'b00}; assert StallM=1 (combinational).
  - Latch word address, ALUResultM[1:0], size and WriteData.
  - Next state is MERGE.
- MERGE, cycle N+1:
  - ram_rdata holds the old word. Drive ram_we=1, ram_addr=latched word address, ram_wdata=merged word, StallM=0.
  - Increment rmw_count; it saturates at all ones.
  - Always return to IDLE.
  - The M-stage inputs still show the same store this cycle. MERGE ignores them, so the store cannot retrigger.
  - The pipeline advances at the end of N+1.
- Merge rules:
  - Byte: lane = addr[1:0]; replace bits [8*lane+7 : 8*lane] with WriteData[7:0]; keep all other bits.
  - Half: lane = addr[1]; replace [15:0] or [31:16] with WriteData[15:0].
  - Half with addr[0]=1: use addr[1] only (same rule as the load formatter). misaligned pulses in cycle N.
- Total cost: 2 cycles per sub-word store, exactly 1 stall cycle.
- Back-to-back sub-word stores:
  - Second store enters IDLE at N+2 and reads at N+2.
  - The write at N+1 has already committed, so the second merge sees the updated word.
  - No forwarding is needed.
- A load immediately after an RMW is issued in IDLE at N+2. There is no port conflict.
- Reset asserted during MERGE: the write is aborted (ram_we=0 immediately) and the count is not incremented.
- Outside MERGE, MemWrite=0 never produces ram_we=1.

Decomposition:
- Shared package mem_pkg:
  - typedef enum logic [1:0] for access size: ACC_WORD=00, ACC_BYTE=01, ACC_HALF=10.
  - FSM state enum.
  - Function merge_word(old, wdata, size, lane).
- The downstream load formatter imports the same size enum from mem_pkg.
- One natural sub-module: store_merge (purely combinational lane merge). The FSM, latches and counter stay in the top module.

Test Plan:
- Preload word 0x10 = 0x11223344. Word store 0xDEADBEEF to 0x10 → ram_we=1 in the same cycle, StallM never 1, word = 0xDEADBEEF, rmw_count=0.
- Preload 0x10 = 0x11223344. sb 0x000000AB to 0x12 → cycle N: StallM=1, ram_we=0, ram_addr=0x10. Cycle N+1: ram_we=1, ram_wdata=0x11AB3344, rmw_count=1.
- Preload 0x10 = 0x11223344. sh 0x0000BEEF to 0x12 → 0xBEEF3344. sh to 0x13 → same result, misaligned=1 for one cycle.
- Back-to-back sb 0xAB to 0x10, then sb 0xCD to 0x11, on 0x11223344 → final word 0x1122CDAB, two single-cycle stalls, rmw_count=2.
- sb to 0x12, rst_n low during MERGE → no write, word stays 0x11223344, state IDLE, StallM=0, rmw_count=0.
- Force rmw_count to all ones, issue one sb → count stays 0xFFFF and the write still occurs.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path.
//   acc_size_t  : access size encoding shared by the store RMW unit and the
//                 downstream load formatter (2'b11 is treated as a word).
//   rmw_state_t : store RMW FSM state type and its state constants.
//   merge_word  : replaces the addressed byte/half lane of an old word.
package mem_pkg;

    typedef enum logic [1:0] {
        ACC_WORD = 2'b00,
        ACC_BYTE = 2'b01,
        ACC_HALF = 2'b10
    } acc_size_t;

    typedef logic [0:0] rmw_state_t;
    localparam rmw_state_t ST_IDLE  = 1'b0;
    localparam rmw_state_t ST_MERGE = 1'b1;

    // lane is the low two address bits. A half access uses only lane[1], so
    // an odd half address lands on the same half the load formatter picks.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input acc_size_t   size,
        input logic [1:0]  lane
    );
        logic [31:0] result;
        result = old_word;
        case (size)
            ACC_BYTE: result[{lane, 3'b000} +: 8]        = wdata[7:0];
            ACC_HALF: result[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default:  result                             = wdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Bundle between the M stage, the store RMW unit and the single-port data RAM.
//   M-stage side : MemWrite, ByteAccessM, ALUResultM, WriteData (in), StallM,
//                  misaligned (out)
//   RAM side     : ram_rdata (in), ram_we, ram_addr, ram_wdata (out)
// slave  = the store RMW unit; master = the environment (pipeline + RAM).
interface store_rmw_unit_if #(
    parameter int ADDR_W = 32
);
    logic              MemWrite;
    logic [1:0]        ByteAccessM;
    logic [ADDR_W-1:0] ALUResultM;
    logic [31:0]       WriteData;
    logic [31:0]       ram_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              StallM;
    logic              misaligned;

    modport slave (
        input  MemWrite, ByteAccessM, ALUResultM, WriteData, ram_rdata,
        output ram_we, ram_addr, ram_wdata, StallM, misaligned
    );

    modport master (
        output MemWrite, ByteAccessM, ALUResultM, WriteData, ram_rdata,
        input  ram_we, ram_addr, ram_wdata, StallM, misaligned
    );
endinterface

// File: rtl/store_rmw_unit_merge.sv
// store_merge: purely combinational lane merge for sub-word stores.
//   old_word : word read back from the data RAM
//   wdata    : right-aligned store data
//   size     : access size (byte or half; anything else passes wdata through)
//   lane     : low two bits of the byte address
//   merged   : word to write back
module store_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  acc_size_t   size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    assign merged = merge_word(old_word, wdata, size, lane);

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: store-side front end for a data RAM without byte enables.
// Word stores and loads pass straight through. Byte/half stores take two
// cycles: read the word (pipeline stalled), then write back the merged word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : M-stage request/stall and data RAM port (slave modport)
//   rmw_count  : saturating count of completed RMW write-backs
module store_rmw_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    store_rmw_unit_if.slave  bus,
    output logic [CNT_W-1:0] rmw_count
);

    rmw_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        lane_reg;
    acc_size_t         size_reg;
    logic [31:0]       data_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              sub_word;
    logic              start_rmw;
    logic [31:0]       merged;

    logic              ram_we_next;
    logic [ADDR_W-1:0] ram_addr_next;
    logic [31:0]       ram_wdata_next;
    logic              stall_next;
    logic              misaligned_next;

    assign sub_word  = bus.MemWrite &&
                       (bus.ByteAccessM == ACC_BYTE || bus.ByteAccessM == ACC_HALF);
    // In MERGE the M stage still shows the same store; only IDLE may start one.
    assign start_rmw = (state_reg == ST_IDLE) && sub_word;

    store_merge u_merge (
        .old_word (bus.ram_rdata),
        .wdata    (data_reg),
        .size     (size_reg),
        .lane     (lane_reg),
        .merged   (merged)
    );

    always_comb begin
        ram_we_next     = bus.MemWrite;
        ram_addr_next   = bus.ALUResultM;
        ram_wdata_next  = bus.WriteData;
        stall_next      = 1'b0;
        misaligned_next = 1'b0;
        state_next      = state_reg;

        if (state_reg == ST_MERGE) begin
            ram_we_next    = 1'b1;
            ram_addr_next  = addr_reg;
            ram_wdata_next = merged;
            state_next     = ST_IDLE;
        end else if (start_rmw) begin
            ram_we_next     = 1'b0;
            ram_addr_next   = {bus.ALUResultM[ADDR_W-1:2], 2'b00};
            stall_next      = 1'b1;
            misaligned_next = (bus.ByteAccessM == ACC_HALF) && bus.ALUResultM[0];
            state_next      = ST_MERGE;
        end

        // Outputs are forced quiet while reset is held, so an in-flight
        // write-back is dropped the moment reset asserts.
        if (!rst_n) begin
            ram_we_next     = 1'b0;
            ram_addr_next   = '0;
            ram_wdata_next  = '0;
            stall_next      = 1'b0;
            misaligned_next = 1'b0;
        end
    end

    assign bus.ram_we     = ram_we_next;
    assign bus.ram_addr   = ram_addr_next;
    assign bus.ram_wdata  = ram_wdata_next;
    assign bus.StallM     = stall_next;
    assign bus.misaligned = misaligned_next;
    assign rmw_count      = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            lane_reg  <= '0;
            size_reg  <= ACC_WORD;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_rmw) begin
                addr_reg <= {bus.ALUResultM[ADDR_W-1:2], 2'b00};
                lane_reg <= bus.ALUResultM[1:0];
                size_reg <= acc_size_t'(bus.ByteAccessM);
                data_reg <= bus.WriteData;
            end
            if (state_reg == ST_MERGE && count_reg != {CNT_W{1'b1}}) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Testbench for store_rmw_unit: a 16-word synchronous RAM model is attached
// to the RAM side; directed and random stores are checked against a
// word-array reference model. The counter is built narrow (CNT_W=4) so the
// saturation boundary can be reached in a handful of stores.
module tb_store_rmw_unit;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] rmw_count;

    store_rmw_unit_if #(.ADDR_W(ADDR_W)) bus ();

    store_rmw_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rmw_count (rmw_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // RAM model: full-word writes, registered read.
    logic [31:0] ram [0:15];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;
    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_val;
        else if (bus.ram_we) ram[bus.ram_addr[5:2]] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr[5:2]];
    end

    // Reference model state.
    logic [31:0]      ref_mem [0:15];
    logic [CNT_W-1:0] ref_count;

    // Observed outputs of the last operation: cycle N and cycle N+1.
    logic              o0_we, o0_stall, o0_mis, o1_we, o1_stall, o1_mis;
    logic [ADDR_W-1:0] o0_addr, o1_addr;
    logic [31:0]       o0_wdata, o1_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_store(input logic [31:0] old_word,
            input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'b01) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
            return (old_word & ~mask) | ((d & 32'h0000_00FF) << sh);
        end else if (sz == 2'b10) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            return (old_word & ~mask) | ((d & 32'h0000_FFFF) << sh);
        end
        return d;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        pre_we  = 1'b1;
        pre_idx = idx[3:0];
        pre_val = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Drives one M-stage access starting just after a rising edge and
    // returns just after the edge that ends it. Sub-word stores are held for
    // the stall cycle, as a frozen pipeline would.
    task automatic run_op(input logic mw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        logic sub;
        sub = mw && (sz == 2'b01 || sz == 2'b10);
        bus.MemWrite = mw; bus.ByteAccessM = sz;
        bus.ALUResultM = a; bus.WriteData = d;
        @(negedge clk);
        o0_we = bus.ram_we; o0_addr = bus.ram_addr; o0_wdata = bus.ram_wdata;
        o0_stall = bus.StallM; o0_mis = bus.misaligned;
        o1_we = 1'b0; o1_addr = '0; o1_wdata = '0; o1_stall = 1'b0; o1_mis = 1'b0;
        if (sub) begin
            @(posedge clk); #1;
            @(negedge clk);
            o1_we = bus.ram_we; o1_addr = bus.ram_addr; o1_wdata = bus.ram_wdata;
            o1_stall = bus.StallM; o1_mis = bus.misaligned;
        end
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        bus.MemWrite = 1'b1; bus.ByteAccessM = 2'b01;
        bus.ALUResultM = 32'h12; bus.WriteData = 32'hAB;
        @(negedge clk);
        n_checks++;
        if ({bus.ram_we, bus.StallM, bus.misaligned} !== 3'b000 ||
            bus.ram_addr !== '0 || bus.ram_wdata !== '0 || rmw_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b stall=%b mis=%b addr=%h wdata=%h cnt=%0d, required all zero",
                     bus.ram_we, bus.StallM, bus.misaligned, bus.ram_addr, bus.ram_wdata, rmw_count);
        end
        bus.MemWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_count = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        $display("test_reset: done");
    endtask

    task automatic test_word_store();
        preload(4, 32'h11223344);
        run_op(1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
        ref_mem[4] = 32'hDEADBEEF;
        n_checks++;
        if (o0_we !== 1'b1 || o0_stall !== 1'b0 || o0_addr !== 32'h10 || o0_wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_store_cycle: we=%b stall=%b addr=%h wdata=%h, required 1 0 00000010 deadbeef",
                     o0_we, o0_stall, o0_addr, o0_wdata);
        end
        n_checks++;
        if (ram[4] !== 32'hDEADBEEF || rmw_count !== ref_count) begin
            n_fail++;
            $display("FAIL word_store_result: word=%h cnt=%0d, required deadbeef %0d", ram[4], rmw_count, ref_count);
        end
        $display("test_word_store: word=%h cnt=%0d", ram[4], rmw_count);
    endtask

    task automatic test_byte_store();
        preload(4, 32'h11223344);
        run_op(1'b1, 2'b01, 32'h12, 32'h000000AB);
        ref_count = ref_count + 1'b1;
        ref_mem[4] = 32'h11AB3344;
        n_checks++;
        if (o0_stall !== 1'b1 || o0_we !== 1'b0 || o0_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL byte_read_cycle: stall=%b we=%b addr=%h, required 1 0 00000010", o0_stall, o0_we, o0_addr);
        end
        n_checks++;
        if (o1_we !== 1'b1 || o1_stall !== 1'b0 || o1_addr !== 32'h10 || o1_wdata !== 32'h11AB3344) begin
            n_fail++;
            $display("FAIL byte_write_cycle: we=%b stall=%b addr=%h wdata=%h, required 1 0 00000010 11ab3344",
                     o1_we, o1_stall, o1_addr, o1_wdata);
        end
        n_checks++;
        if (ram[4] !== 32'h11AB3344 || rmw_count !== ref_count) begin
            n_fail++;
            $display("FAIL byte_result: word=%h cnt=%0d, required 11ab3344 %0d", ram[4], rmw_count, ref_count);
        end
        $display("test_byte_store: word=%h cnt=%0d", ram[4], rmw_count);
    endtask

    task automatic test_half_store();
        logic [31:0] addrs [2];
        addrs[0] = 32'h12; addrs[1] = 32'h13;
        for (int k = 0; k < 2; k++) begin
            preload(4, 32'h11223344);
            run_op(1'b1, 2'b10, addrs[k], 32'h0000BEEF);
            ref_count = ref_count + 1'b1;
            ref_mem[4] = 32'hBEEF3344;
            n_checks++;
            if (o0_stall !== 1'b1 || o0_mis !== (k == 1) || o1_mis !== 1'b0) begin
                n_fail++;
                $display("FAIL half_flags addr=%h: stall=%b mis_n=%b mis_n1=%b, required 1 %b 0",
                         addrs[k], o0_stall, o0_mis, o1_mis, k == 1);
            end
            n_checks++;
            if (o1_wdata !== 32'hBEEF3344 || ram[4] !== 32'hBEEF3344 || rmw_count !== ref_count) begin
                n_fail++;
                $display("FAIL half_result addr=%h: wdata=%h word=%h cnt=%0d, required beef3344 beef3344 %0d",
                         addrs[k], o1_wdata, ram[4], rmw_count, ref_count);
            end
            $display("test_half_store: addr=%h word=%h mis=%b", addrs[k], ram[4], o0_mis);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        preload(4, 32'h11223344);
        stalls = 0;
        run_op(1'b1, 2'b01, 32'h10, 32'hAB);
        stalls += int'(o0_stall) + int'(o1_stall);
        run_op(1'b1, 2'b01, 32'h11, 32'hCD);
        stalls += int'(o0_stall) + int'(o1_stall);
        ref_count = ref_count + 2'd2;
        ref_mem[4] = 32'h1122CDAB;
        n_checks++;
        if (o1_wdata !== 32'h1122CDAB || ram[4] !== 32'h1122CDAB) begin
            n_fail++;
            $display("FAIL b2b_word: wdata=%h word=%h, required 1122cdab", o1_wdata, ram[4]);
        end
        n_checks++;
        if (stalls != 2 || rmw_count !== ref_count) begin
            n_fail++;
            $display("FAIL b2b_stalls: stalls=%0d cnt=%0d, required 2 %0d", stalls, rmw_count, ref_count);
        end
        $display("test_back_to_back: word=%h stalls=%0d cnt=%0d", ram[4], stalls, rmw_count);
    endtask

    task automatic test_reset_in_merge();
        preload(4, 32'h11223344);
        bus.MemWrite = 1'b1; bus.ByteAccessM = 2'b01;
        bus.ALUResultM = 32'h12; bus.WriteData = 32'hAB;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ram_we !== 1'b0 || bus.StallM !== 1'b0 || rmw_count !== '0) begin
            n_fail++;
            $display("FAIL merge_reset_outputs: we=%b stall=%b cnt=%0d, required 0 0 0",
                     bus.ram_we, bus.StallM, rmw_count);
        end
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_count = '0;
        @(posedge clk); #1;
        n_checks++;
        if (ram[4] !== 32'h11223344 || rmw_count !== '0) begin
            n_fail++;
            $display("FAIL merge_reset_word: word=%h cnt=%0d, required 11223344 0", ram[4], rmw_count);
        end
        // Back in IDLE: a word store must write in its own cycle.
        run_op(1'b1, 2'b00, 32'h14, 32'hCAFEF00D);
        ref_mem[5] = 32'hCAFEF00D;
        n_checks++;
        if (o0_we !== 1'b1 || o0_stall !== 1'b0 || ram[5] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL merge_reset_idle: we=%b stall=%b word=%h, required 1 0 cafef00d", o0_we, o0_stall, ram[5]);
        end
        $display("test_reset_in_merge: word=%h cnt=%0d", ram[4], rmw_count);
    endtask

    task automatic test_random();
        logic        mw, sub;
        logic [1:0]  sz;
        logic [31:0] a, d, exp_word;
        int          idx;
        for (int t = 0; t < 60; t++) begin
            mw  = ($urandom_range(3) != 0);
            sz  = 2'($urandom_range(3));
            a   = 32'($urandom_range(63));
            d   = $urandom;
            idx = int'(a[5:2]);
            sub = mw && (sz == 2'b01 || sz == 2'b10);
            exp_word = sub ? ref_store(ref_mem[idx], a, d, sz) : d;
            run_op(mw, sz, a, d);
            if (sub) begin
                if (ref_count != CNT_MAX) ref_count = ref_count + 1'b1;
                ref_mem[idx] = exp_word;
                n_checks++;
                if (o0_stall !== 1'b1 || o0_we !== 1'b0 || o0_addr !== {a[31:2], 2'b00} ||
                    o0_mis !== (sz == 2'b10 && a[0])) begin
                    n_fail++;
                    $display("FAIL rand_read t=%0d: stall=%b we=%b addr=%h mis=%b, required 1 0 %h %b",
                             t, o0_stall, o0_we, o0_addr, o0_mis, {a[31:2], 2'b00}, sz == 2'b10 && a[0]);
                end
                n_checks++;
                if (o1_we !== 1'b1 || o1_stall !== 1'b0 || o1_addr !== {a[31:2], 2'b00} || o1_wdata !== exp_word) begin
                    n_fail++;
                    $display("FAIL rand_write t=%0d: we=%b stall=%b addr=%h wdata=%h, required 1 0 %h %h",
                             t, o1_we, o1_stall, o1_addr, o1_wdata, {a[31:2], 2'b00}, exp_word);
                end
            end else begin
                if (mw) ref_mem[idx] = d;
                n_checks++;
                if (o0_we !== mw || o0_stall !== 1'b0 || o0_addr !== a || o0_wdata !== d || o0_mis !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_pass t=%0d: we=%b stall=%b addr=%h wdata=%h mis=%b, required %b 0 %h %h 0",
                             t, o0_we, o0_stall, o0_addr, o0_wdata, o0_mis, mw, a, d);
                end
            end
            n_checks++;
            if (ram[idx] !== ref_mem[idx] || rmw_count !== ref_count) begin
                n_fail++;
                $display("FAIL rand_state t=%0d: word=%h cnt=%0d, required %h %0d",
                         t, ram[idx], rmw_count, ref_mem[idx], ref_count);
            end
            $display("test_random t=%0d: mw=%b sz=%0d addr=%h data=%h word=%h cnt=%0d",
                     t, mw, sz, a, d, ram[idx], rmw_count);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_word;
        for (int i = 0; i < 20 && ref_count != CNT_MAX; i++) begin
            run_op(1'b1, 2'b01, 32'h20, 32'($urandom_range(255)));
            ref_count = ref_count + 1'b1;
            ref_mem[8] = ram[8];
        end
        preload(8, 32'h11223344);
        exp_word = ref_store(32'h11223344, 32'h22, 32'h5A, 2'b01);
        run_op(1'b1, 2'b01, 32'h22, 32'h5A);
        ref_mem[8] = exp_word;
        n_checks++;
        if (rmw_count !== CNT_MAX) begin
            n_fail++;
            $display("FAIL sat_count: cnt=%0d, required %0d", rmw_count, CNT_MAX);
        end
        n_checks++;
        if (o1_we !== 1'b1 || ram[8] !== exp_word) begin
            n_fail++;
            $display("FAIL sat_write: we=%b word=%h, required 1 %h", o1_we, ram[8], exp_word);
        end
        $display("test_saturation: cnt=%0d word=%h", rmw_count, ram[8]);
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_half_store();
        test_back_to_back();
        test_reset_in_merge();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
